// File: rtl/instr_encoder.sv
// Streaming RV32I field-to-word encoder with range checking, a small output FIFO
// and saturating word/error counters.
module instr_encoder #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DepthC = (PW+1)'(DEPTH);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;

  logic [31:0]   mem_instr [DEPTH];
  logic          mem_err   [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [31:0]   enc_instr;
  logic          enc_err;
  logic signed [31:0] simm;
  logic          accept, emit;

  assign simm      = in_imm;
  assign in_ready  = count < DepthC;
  assign out_valid = count != '0;
  assign out_instr = mem_instr[rd_ptr];
  assign out_err   = mem_err[rd_ptr];
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  // Out-of-range immediates are still packed from their truncated bits.
  always_comb begin
    enc_instr = 32'h0;
    enc_err   = 1'b0;
    unique case (in_opcode)
      OpLoad, OpImm, OpJalr: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = (simm < -2048) || (simm > 2047);
      end
      OpStore: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err   = (simm < -2048) || (simm > 2047);
      end
      OpBranch: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                     in_imm[11], in_opcode};
        enc_err   = (simm < -4096) || (simm > 4094) || in_imm[0];
      end
      OpLui, OpAuipc: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_err   = in_imm[11:0] != 12'h0;
      end
      OpJal: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = (simm < -1048576) || (simm > 1048574) || in_imm[0];
      end
      OpReg: begin
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      default: begin
        enc_instr = 32'h0;
        enc_err   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= 32'h0;
        mem_err[i]   <= 1'b0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (accept) begin
        mem_instr[wr_ptr] <= enc_instr;
        mem_err[wr_ptr]   <= enc_err;
        wr_ptr            <= wr_ptr + PW'(1);
        if (enc_count != '1) enc_count <= enc_count + CNT_W'(1);
        if (enc_err && (err_count != '1)) err_count <= err_count + CNT_W'(1);
      end
      if (emit) rd_ptr <= rd_ptr + PW'(1);
      if (accept && !emit)      count <= count + (PW+1)'(1);
      else if (!accept && emit) count <= count - (PW+1)'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised scoreboard bench for instr_encoder: a driver pushes expected words,
// an independent monitor pops and compares each emitted word.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count, err_count;

  instr_encoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_enc = 0;
  int exp_err = 0;
  logic [32:0] sb_q[$];

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: builds the word field by field with shifts and masks.
  function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    longint s;
    logic [31:0] w;
    logic e;
    logic [31:0] base;
    s = longint'($signed(imm));
    base = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
    e = 1'b0;
    case (op)
      7'h03, 7'h13, 7'h67: begin
        w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
        e = (s < -2048) || (s > 2047);
      end
      7'h23: begin
        w = (((imm >> 5) & 32'h7F) << 25) | base | ((imm & 32'h1F) << 7);
        e = (s < -2048) || (s > 2047);
      end
      7'h63: begin
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | base
          | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
        e = (s < -4096) || (s > 4094) || (s % 2 != 0);
      end
      7'h37, 7'h17: begin
        w = (imm & 32'hFFFFF000) | (32'(rd) << 7);
        e = (imm % 4096) != 0;
      end
      7'h6F: begin
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
          | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7);
        e = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      end
      7'h33: w = (32'(f7) << 25) | base | (32'(rd) << 7);
      default: begin
        w = 32'h0;
        e = 1'b1;
      end
    endcase
    if (op inside {7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33})
      w = w | 32'(op);
    return {e, w};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, input bit use_exp, input logic [32:0] exp);
    logic rdy;
    bit done;
    logic [32:0] e;
    done = 0;
    e = use_exp ? exp : model(op, rd, rs1, rs2, f3, f7, imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        sb_q.push_back(e);
        exp_enc++;
        if (e[32]) exp_err++;
        done = 1;
      end
    end
    #1 in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain_left", 33'(sb_q.size()), 33'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops on every emit and checks head stability under backpressure.
  logic        held_v = 1'b0;
  logic [32:0] held;
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) chk("hold_stable", {out_err, out_instr}, held);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("unexpected_word", {out_err, out_instr}, 33'h0_0000_0000 ^ 33'h1_FFFF_FFFF);
        else chk("word", {out_err, out_instr}, sb_q.pop_front());
      end
      held_v = out_valid && !out_ready;
      held = {out_err, out_instr};
    end
  end

  logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
  bit stop_rdy;

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 33'(out_valid), 33'd0);
    chk("rst_out_word", {out_err, out_instr}, 33'd0);
    chk("rst_counts", 33'({enc_count, err_count}), 33'd0);
    chk("rst_in_ready", 33'(in_ready), 33'd1);
    @(posedge clk); #1;

    out_ready = 1'b1;
    send(7'h13, 1, 0, 0, 0, 0, 32'd5, 1, {1'b0, 32'h00500093});
    send(7'h23, 0, 1, 2, 2, 0, 32'd8, 1, {1'b0, 32'h0020A423});
    send(7'h63, 0, 0, 0, 0, 0, -32'sd4, 1, {1'b0, 32'hFE000EE3});
    send(7'h6F, 0, 0, 0, 0, 0, 32'd0, 1, {1'b0, 32'h0000006F});
    send(7'h37, 5, 0, 0, 0, 0, 32'h12345000, 1, {1'b0, 32'h123452B7});
    send(7'h13, 1, 0, 0, 0, 0, 32'd2048, 1, {1'b1, 32'h80000093});
    chk("err_count_first", 33'(err_count), 33'd1);
    send(7'h63, 0, 0, 0, 0, 0, 32'd6, 1, {1'b0, 32'h00000363});
    send(7'h63, 0, 0, 0, 0, 0, 32'd3, 1, {1'b1, 32'h00000163});
    send(7'h7F, 3, 4, 5, 1, 0, 32'd7, 1, {1'b1, 32'h00000000});
    drain();
    chk("enc_count_directed", 33'(enc_count), 33'(exp_enc));
    chk("err_count_directed", 33'(err_count), 33'(exp_err));

    // Reset with two words buffered.
    out_ready = 1'b0;
    send(7'h33, 1, 2, 3, 0, 7'h20, 0, 0, 0);
    send(7'h13, 4, 5, 0, 0, 0, 32'd100, 0, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 33'(out_valid), 33'd0);
    chk("arst_counts", 33'({enc_count, err_count}), 33'd0);
    sb_q.delete();
    exp_enc = 0; exp_err = 0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_empty", 33'(out_valid), 33'd0);
    end
    @(posedge clk); #1;

    // Backpressure: third bundle waits until the first word leaves.
    out_ready = 1'b0;
    send(7'h13, 1, 1, 0, 0, 0, 32'd1, 0, 0);
    send(7'h13, 2, 2, 0, 0, 0, 32'd2, 0, 0);
    fork
      send(7'h13, 3, 3, 0, 0, 0, 32'd3, 0, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("full_in_ready", 33'(in_ready), 33'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("before_emit_ready", 33'(in_ready), 33'd0);
        @(negedge clk);
        chk("after_emit_ready", 33'(in_ready), 33'd1);
      end
    join
    drain();
    chk("bp_enc_count", 33'(enc_count), 33'd3);

    // Streaming at occupancy one.
    out_ready = 1'b0;
    send(7'h33, 7, 8, 9, 3, 0, 0, 0, 0);
    out_ready = 1'b1;
    fork
      for (int i = 0; i < 10; i++)
        send(7'h13, 5'(i), 5'(i + 1), 0, 3'(i), 0, 32'(i * 3), 0, 0);
      repeat (10) begin
        @(negedge clk);
        chk("occ1_valid_ready", 33'({out_valid, in_ready}), 33'b11);
      end
    join
    drain();

    // Random traffic with random backpressure.
    stop_rdy = 0;
    fork
      while (!stop_rdy) begin
        @(posedge clk);
        #1 out_ready = 1'($urandom_range(0, 1));
      end
      begin
        for (int i = 0; i < 300; i++) begin
          logic [31:0] imm;
          logic [6:0] op;
          op = (i % 13 == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
          case ($urandom_range(0, 3))
            0: imm = 32'($signed($urandom_range(0, 10000)) - 5000);
            1: imm = 32'($signed($urandom_range(0, 4200000)) - 2100000);
            2: imm = $urandom;
            default: imm = $urandom & 32'hFFFFF000;
          endcase
          send(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
               imm, 0, 0);
        end
        stop_rdy = 1;
      end
    join
    out_ready = 1'b1;
    drain();
    chk("final_enc_count", 33'(enc_count), 33'(exp_enc));
    chk("final_err_count", 33'(err_count), 33'(exp_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder. It packs decoded fields (opcode, registers, funct, full 32-bit immediate) back into a 32-bit instruction word.
- It is the inverse of the core's immediate generator, covering the I, S, B, U, J and R formats.
- It feeds the self-test instruction loader and the bench stimulus path.
- Words are range-checked and buffered in a small output FIFO with valid/ready on both sides.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- CNT_W, 16, width of the encoded-word and error counters

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle
- in_opcode  input  7  major opcode
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R-type only)
- in_imm  input  32  signed byte-offset / value immediate, same meaning as the immediate generator output
- out_valid  output  1  encoded word available
- out_ready  input  1  consumer accepts word
- out_instr  output  32  encoded instruction
- out_err  output  1  this word had an immediate-range or opcode error
- enc_count  output  CNT_W  words accepted since reset, saturating
- err_count  output  CNT_W  words flagged out_err since reset, saturating

Behaviour:
- Reset (async): FIFO empty, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0. in_ready=1 once reset deasserts.
- Reset mid-operation discards all buffered words; nothing is emitted afterward.
- Accept: in_valid & in_ready at a rising edge.
- Emit: out_valid & out_ready at a rising edge.
- in_ready = (occupancy < DEPTH). It is combinational from state only, never from out_ready.
- No same-cycle pass-through when full.
- When not full, a simultaneous accept and emit leaves occupancy unchanged.
- Latency: a word accepted at edge N is visible on out_valid/out_instr after edge N (earliest one emit at edge N+1).
- out_* are driven from the FIFO head register. They are stable while out_valid & !out_ready.
- Order is strictly FIFO. Pointers wrap modulo DEPTH.
- Encoding by in_opcode (imm = in_imm):
  - I (0000011, 0010011, 1100111): {imm[11:0], rs1, f3, rd, op}
  - S (0100011): {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - U (0110111, 0010111): {imm[31:12], rd, op}
  - J (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
  - R (0110011): {f7, rs2, rs1, f3, rd, op}
- Range check (signed). The error flag is set, but the word is still encoded from the truncated bits:
  - I, S: imm in [-2048, 2047]
  - B: imm in [-4096, 4094] and imm[0]=0
  - J: imm in [-1048576, 1048574] and imm[0]=0
  - U: imm[11:0]=0
  - R: imm ignored, never errors
- Unsupported opcode: out_instr=32'h0, out_err=1.
- Counters update on the accept edge:
  - enc_count += 1
  - err_count += 1 if the word's error flag is set
  - Both hold at all-ones.

Test Plan:
- Single-word encodes, out_ready=1 (out_err=0 on each):
  - addi: op=0010011 rd=1 rs1=0 f3=0 imm=5 -> out_instr=0x00500093
  - sw: op=0100011 rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423
- Branch/jump/upper:
  - beq: op=1100011 rs1=0 rs2=0 imm=-4 -> 0xFE000EE3
  - jal: op=1101111 rd=0 imm=0 -> 0x0000006F
  - lui: op=0110111 rd=5 imm=0x12345000 -> 0x123452B7
- Range errors:
  - addi rd=1 imm=2048 -> 0x80000093, out_err=1, err_count=1
  - beq imm=6, then imm=3 -> both words out_err=0 then 1
  - op=1111111 -> 0x00000000, out_err=1
- Backpressure (out_ready=0, DEPTH=2):
  - Push 3 bundles back-to-back -> in_ready=0 after 2nd accept, 3rd held.
  - Raise out_ready -> words emerge in order, 3rd accepted the edge after 1st emit.
  - enc_count=3.
- Simultaneous accept/emit at occupancy 1 for 10 cycles -> occupancy stays 1, no drops or duplicates, words in order.
- Assert rst with 2 words buffered -> out_valid=0 immediately (async), both counters 0, no stale word after release.
